// File: rtl/ssd_if.sv
// ssd_if: display data, control and pin-side signals of the scan driver.
interface ssd_if #(
  parameter int NUM_DIGITS = 8
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    load;
  logic                    lz_blank;
  logic [3:0]              brightness;
  logic                    loaded;
  logic [IW-1:0]           digit_idx;
  logic [NUM_DIGITS-1:0]   anodes;
  logic [7:0]              cathodes;
  modport master (
    output value, dp, digit_en, load, lz_blank, brightness,
    input  loaded, digit_idx, anodes, cathodes
  );
  modport slave (
    input  value, dp, digit_en, load, lz_blank, brightness,
    output loaded, digit_idx, anodes, cathodes
  );
endinterface

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: multiplexed N-digit seven-segment driver with double-buffered data, LZ blanking and PWM.
module ssd_scan_driver #(
  parameter int NUM_DIGITS    = 8,
  parameter int SCAN_DIV_BITS = 18,
  parameter int GUARD_CYCLES  = 16
) (
  input logic clk,
  input logic rst,
  ssd_if.slave bus
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic [SCAN_DIV_BITS-1:0] pc;
  logic [IW-1:0]            idx;
  logic [4*NUM_DIGITS-1:0]  act_val, sh_val;
  logic [NUM_DIGITS-1:0]    act_dp, act_en, sh_dp, sh_en, an_nxt;
  logic                     pending, term, fb, z, cur_dp, cur_en, blank;
  logic [3:0]               nib;
  logic [7:0]               cat_nxt;

  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
  endfunction

  assign term = &pc;
  assign fb = term && idx == IW'(NUM_DIGITS-1);
  assign bus.digit_idx = idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc  <= '0;
      idx <= '0;
    end else begin
      pc <= pc + 1'b1;
      if (term) idx <= fb ? '0 : idx + 1'b1;
    end
  end

  // A load landing on the frame boundary bypasses the shadow entirely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {act_val, act_dp, act_en} <= '0;
      {sh_val, sh_dp, sh_en}    <= '0;
      pending    <= 1'b0;
      bus.loaded <= 1'b0;
    end else begin
      bus.loaded <= fb && (bus.load || pending);
      if (bus.load && !fb) begin
        {sh_val, sh_dp, sh_en} <= {bus.value, bus.dp, bus.digit_en};
        pending <= 1'b1;
      end else if (fb) pending <= 1'b0;
      if (fb && (bus.load || pending))
        {act_val, act_dp, act_en} <= bus.load ? {bus.value, bus.dp, bus.digit_en}
                                              : {sh_val, sh_dp, sh_en};
    end
  end

  // Walk from the top digit down so z means "this digit and all above are zero".
  always_comb begin
    z      = 1'b1;
    nib    = '0;
    cur_dp = 1'b0;
    cur_en = 1'b0;
    blank  = 1'b0;
    an_nxt = '1;
    for (int i = NUM_DIGITS-1; i >= 0; i--) begin
      z = z && act_val[4*i +: 4] == 4'h0;
      if (idx == IW'(i)) begin
        nib       = act_val[4*i +: 4];
        cur_dp    = act_dp[i];
        cur_en    = act_en[i];
        blank     = bus.lz_blank && i != 0 && z;
        an_nxt[i] = !(act_en[i] && pc >= SCAN_DIV_BITS'(GUARD_CYCLES)
                      && pc[SCAN_DIV_BITS-1 -: 4] <= bus.brightness);
      end
    end
    cat_nxt = cur_en ? {blank ? 7'h7F : seg(nib), ~cur_dp} : 8'hFF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.anodes   <= '1;
      bus.cathodes <= 8'hFF;
    end else begin
      bus.anodes   <= an_nxt;
      bus.cathodes <= cat_nxt;
    end
  end
endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb_ssd_scan_driver: directed checks of scan timing, loading, blanking, PWM and reset (4 digits, 64-cycle slots).
module tb_ssd_scan_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  ssd_if #(.NUM_DIGITS(4)) bus ();
  ssd_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV_BITS(6), .GUARD_CYCLES(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;

  int t = 0, vecs = 0, errs = 0, lp = 0, lt = -1, bad = 0;
  int lo[4];
  int ts[7] = '{63, 64, 127, 128, 192, 255, 256};
  int ix[7] = '{0, 1, 1, 2, 3, 3, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  // t counts clock edges since reset release; phase = t % 256 within a frame
  task automatic tick();
    @(negedge clk);
    t++;
    if (bus.loaded) begin
      lp++;
      lt = t % 256;
    end
  endtask

  task automatic to_phase(input int m);
    do tick(); while (t % 256 != m);
  endtask

  task automatic count_frame();
    lo = '{default: 0};
    repeat (256) begin
      tick();
      for (int d = 0; d < 4; d++) if (!bus.anodes[d]) lo[d]++;
    end
  endtask

  task automatic pulse_load(input logic [15:0] v);
    bus.value = v;
    bus.load  = 1'b1;
    tick();
    bus.load  = 1'b0;
  endtask

  task automatic wait_loaded();
    int n = 0;
    lp = 0;
    while (lp == 0 && n < 300) begin
      tick();
      n++;
    end
    chk("loaded_seen", lp, 1);
  endtask

  initial begin
    bus.value = '0; bus.dp = '0; bus.digit_en = '0;
    bus.load = 1'b0; bus.lz_blank = 1'b0; bus.brightness = 4'd15;
    repeat (3) @(negedge clk);
    chk("rst_anodes", bus.anodes, 4'hF);
    chk("rst_cathodes", bus.cathodes, 8'hFF);
    chk("rst_idx", bus.digit_idx, 0);
    chk("rst_loaded", bus.loaded, 0);
    rst = 1'b0;
    t = 0;
    for (int k = 1; k <= 1000; k++) begin
      tick();
      if (bus.anodes !== 4'hF || bus.cathodes !== 8'hFF) bad++;
      for (int j = 0; j < 7; j++) if (t == ts[j]) chk("idx_step", bus.digit_idx, ix[j]);
    end
    chk("dark_1000", bad, 0);

    bus.digit_en = 4'hF; bus.dp = 4'b0100; lp = 0;
    pulse_load(16'h12AF);
    to_phase(30);
    chk("load_pulses", lp, 1);
    chk("load_phase", lt, 0);
    to_phase(1);
    chk("guard_pc0", bus.anodes, 4'hF);
    chk("dig0_cat_pc0", bus.cathodes, 8'b01110001);
    to_phase(2);
    chk("guard_pc1", bus.anodes, 4'hF);
    to_phase(3);
    chk("lit_pc2", bus.anodes, 4'b1110);
    to_phase(10);
    chk("dig0_cat", bus.cathodes, 8'b01110001);
    to_phase(138);
    chk("dig2_cat", bus.cathodes, 8'b00100100);
    chk("dig2_an", bus.anodes, 4'b1011);
    lp = 0;
    count_frame();
    for (int d = 0; d < 4; d++) chk("duty15", lo[d], 62);
    chk("no_spurious_loaded", lp, 0);

    bus.brightness = 4'd3;
    count_frame();
    for (int d = 0; d < 4; d++) chk("duty3", lo[d], 14);
    to_phase(16);
    chk("b3_pc15", bus.anodes, 4'b1110);
    to_phase(17);
    chk("b3_pc16", bus.anodes, 4'hF);
    bus.brightness = 4'd0;
    count_frame();
    for (int d = 0; d < 4; d++) chk("duty0", lo[d], 2);

    bus.brightness = 4'd15; bus.dp = 4'b0000; bus.lz_blank = 1'b1;
    pulse_load(16'h0050);
    wait_loaded();
    to_phase(10);
    chk("lz_dig0", bus.cathodes, 8'b00000011);
    to_phase(74);
    chk("lz_dig1", bus.cathodes, 8'b01001001);
    to_phase(138);
    chk("lz_dig2", bus.cathodes, 8'hFF);
    chk("lz_dig2_an", bus.anodes, 4'b1011);
    to_phase(202);
    chk("lz_dig3", bus.cathodes, 8'hFF);
    pulse_load(16'h0000);
    wait_loaded();
    to_phase(10);
    chk("zero_dig0", bus.cathodes, 8'b00000011);
    to_phase(74);
    chk("zero_dig1_blank", bus.cathodes, 8'hFF);
    bus.lz_blank = 1'b0;
    to_phase(80);
    chk("lz_off_live", bus.cathodes, 8'b00000011);

    to_phase(100);
    lp = 0;
    bus.value = 16'h1111; bus.load = 1'b1;
    tick();
    bus.value = 16'h2222;
    tick();
    bus.load = 1'b0;
    to_phase(200);
    chk("b2b_old_shown", bus.cathodes, 8'b00000011);
    to_phase(5);
    chk("b2b_pulses", lp, 1);
    chk("b2b_phase", lt, 0);
    to_phase(10);
    chk("b2b_dig0", bus.cathodes, 8'b00100101);
    to_phase(74);
    chk("b2b_dig1", bus.cathodes, 8'b00100101);

    to_phase(255);
    bus.value = 16'h3333; bus.load = 1'b1;
    tick();
    chk("edge_loaded", bus.loaded, 1);
    bus.load = 1'b0;
    tick();
    chk("edge_loaded_off", bus.loaded, 0);
    to_phase(10);
    chk("edge_dig0", bus.cathodes, 8'b00001101);
    lp = 0;
    to_phase(5);
    chk("edge_no_pending", lp, 0);

    to_phase(100);
    pulse_load(16'h4444);
    to_phase(148);
    chk("pre_rst_an", bus.anodes, 4'b1011);
    rst = 1'b1;
    #1;
    chk("arst_anodes", bus.anodes, 4'hF);
    chk("arst_cathodes", bus.cathodes, 8'hFF);
    chk("arst_idx", bus.digit_idx, 0);
    chk("arst_loaded", bus.loaded, 0);
    @(negedge clk);
    rst = 1'b0;
    t = 0; lp = 0; bad = 0;
    repeat (300) begin
      tick();
      if (bus.anodes !== 4'hF || bus.cathodes !== 8'hFF) bad++;
    end
    chk("post_rst_dark", bad, 0);
    chk("post_rst_no_load", lp, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
